// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth multiplier family.
//   - FSM state encoding (legacy-compatible localparams plus a typed enum)
//   - Booth digit select encoding produced by booth_r4_encoder
//   - booth_iters(): number of radix-4 iterations for a given operand width
// No ports (package).
// ---------------------------------------------------------------------------
package booth_pkg;

    // Raw state codes. The enum below is built on them so that older code
    // comparing against plain 2-bit constants still matches.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Selected multiple of the multiplicand for one radix-4 digit.
    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        PLUS1  = 3'd1,
        PLUS2  = 3'd2,
        MINUS1 = 3'd3,
        MINUS2 = 3'd4
    } digit_e;

    // Operands are extended by two bits (WIDTH+2, always even), and each
    // iteration retires two multiplier bits.
    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// ---------------------------------------------------------------------------
// booth_r4_encoder
// Combinational radix-4 Booth recoder: maps the overlapping 3-bit multiplier
// window {q[i+1], q[i], q[i-1]} to a digit select in {0, +-1, +-2}.
// Ports:
//   window_i  in  3  multiplier window, MSB first
//   sel_o     out    digit select (booth_pkg::digit_e)
// ---------------------------------------------------------------------------
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] window_i,
    output digit_e     sel_o
);

    always_comb begin
        sel_o = ZERO;
        case (window_i)
            3'b000:  sel_o = ZERO;
            3'b001:  sel_o = PLUS1;
            3'b010:  sel_o = PLUS1;
            3'b011:  sel_o = PLUS2;
            3'b100:  sel_o = MINUS2;
            3'b101:  sel_o = MINUS1;
            3'b110:  sel_o = MINUS1;
            3'b111:  sel_o = ZERO;
            default: sel_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_r4.sv
// ---------------------------------------------------------------------------
// booth_mult_r4
// Sequential radix-4 Booth multiplier with run-time signed/unsigned mode.
// One multiply at a time; two multiplier bits are retired per RUN cycle.
//
// Ports:
//   clk          in   1         rising-edge clock
//   rst          in   1         asynchronous active-high reset
//   start        in   1         request, accepted only in IDLE
//   signed_mode  in   1         1 = two's complement, 0 = unsigned
//   Md           in   WIDTH     multiplicand, captured on accepted start
//   Mr           in   WIDTH     multiplier, captured on accepted start
//   busy         out  1         high while RUN or DONE
//   done         out  1         one-cycle pulse when P is updated
//   P            out  2*WIDTH   product register, held until next completion
//   dbg_state_o  out  2         current FSM state (booth_pkg state codes)
//
// Handshake: start is sampled on every rising edge but only acts in IDLE;
// the accepting edge captures Md/Mr/signed_mode, after which those inputs
// may change freely. busy rises the cycle after acceptance and stays high
// through the DONE state. The DONE state's edge writes P and raises done
// for exactly one cycle; by then the FSM is back in IDLE, so a start held
// high in that done cycle is accepted at the following edge. start while
// busy is ignored and nothing is re-sampled.
//
// WIDTH must be even and >= 4.
// ---------------------------------------------------------------------------
module booth_mult_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     Md,
    input  logic [WIDTH-1:0]     Mr,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic [1:0]           dbg_state_o
);

    // Extended operand width and iteration count.
    localparam int E  = WIDTH + 2;
    localparam int N  = booth_iters(WIDTH);
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [E:0]         a_q, a_d;       // accumulator, E+1 bits
    logic [E-1:0]       q_q, q_d;       // multiplier shift register
    logic               qm1_q, qm1_d;   // bit shifted out below Q[0]
    logic [E:0]         m_q, m_d;       // extended multiplicand
    logic [CW-1:0]      cnt_q, cnt_d;   // remaining RUN iterations
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;

    // -----------------------------------------------------------------------
    // Operand extension: sign-extend in signed mode, zero-extend otherwise.
    // The extra high bits make an unsigned WIDTH-bit operand a positive
    // value in the signed datapath, so one algorithm covers both modes.
    // -----------------------------------------------------------------------
    logic       md_ext_bit;
    logic       mr_ext_bit;
    logic [E:0] md_ext;
    logic [E-1:0] mr_ext;

    assign md_ext_bit = signed_mode & Md[WIDTH-1];
    assign mr_ext_bit = signed_mode & Mr[WIDTH-1];
    assign md_ext     = {{3{md_ext_bit}}, Md};
    assign mr_ext     = {{2{mr_ext_bit}}, Mr};

    // -----------------------------------------------------------------------
    // Booth digit and partial-product add
    // -----------------------------------------------------------------------
    digit_e     sel;
    logic [E:0] m_x2;
    logic [E:0] addend;
    logic [E:0] a_sum;

    booth_r4_encoder u_enc (
        .window_i ({q_q[1:0], qm1_q}),
        .sel_o    (sel)
    );

    // M fits in E-1 significant bits, so 2M still fits the E+1-bit accumulator.
    assign m_x2 = {m_q[E-1:0], 1'b0};

    always_comb begin
        addend = '0;
        case (sel)
            ZERO:    addend = '0;
            PLUS1:   addend = m_q;
            PLUS2:   addend = m_x2;
            MINUS1:  addend = -m_q;
            MINUS2:  addend = -m_x2;
            default: addend = '0;
        endcase
    end

    assign a_sum = a_q + addend;

    // Arithmetic shift right by two of {A', Q, q_m1}: the two low accumulator
    // bits move into the top of Q, and q_m1 picks up the old Q[1].
    logic [E:0]   a_shift;
    logic [E-1:0] q_shift;

    assign a_shift = {{2{a_sum[E]}}, a_sum[E:2]};
    assign q_shift = {a_sum[1:0], q_q[E-1:2]};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = md_ext;
                    q_d     = mr_ext;
                    qm1_d   = 1'b0;
                    a_d     = '0;
                    cnt_d   = CNT_N;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d   = a_shift;
                q_d   = q_shift;
                qm1_d = q_q[1];
                cnt_d = cnt_q - CNT_ONE;
                // Last digit retired this cycle; counter lands on 0.
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Full product lives in {A, Q}; the low 2*WIDTH bits are exact
                // in both modes, the upper bits are only sign/guard bits.
                p_d     = {a_q[2*WIDTH-E-1:0], q_q};
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign P           = p_q;
    assign dbg_state_o = state_q;

endmodule
